pedal_delay: RTL and testbench

- Echo/delay effect stage between i2s_rx and i2s_tx in the pedal datapath, clocked on mck.
- Detects each lrck transition and takes the 24-bit word just decoded by i2s_rx.
- Mixes that word with a delayed copy from an interleaved stereo circular buffer, with feedback.
- Presents the result as a registered word for i2s_tx to shift out.

---
 rtl/pedal_pkg.sv | 43 ++++
 rtl/pedal_if.sv | 30 +++
 rtl/pedal_delay_ram.sv | 23 ++
 rtl/pedal_delay.sv | 129 ++++++++++++
 tb/tb_pedal_delay.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pedal_pkg.sv
// pedal_pkg: shared widths, FSM states and fixed-point helpers for the
// echo/delay stage.
package pedal_pkg;

  localparam int DATA_W = 24;
  localparam int GAIN_W = 4;
  localparam int FB_W   = 3;
  localparam int FRAC   = 3;
  localparam int ACC_W  = DATA_W + 2;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    MIX,
    WRITE
  } state_t;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam acc_t S_MAX = acc_t'(2**(DATA_W-1) - 1);
  localparam acc_t S_MIN = acc_t'(-(2**(DATA_W-1)));

  // Full-width product, then drop FRAC bits; magnitude never exceeds |d|.
  function automatic acc_t scale(sample_t d, logic [GAIN_W-1:0] g);
    logic signed [DATA_W+GAIN_W:0] p;
    p = $signed({{(GAIN_W+1){d[DATA_W-1]}}, d})
      * $signed({{(DATA_W+1){1'b0}}, g});
    p = p >>> FRAC;
    return p[ACC_W-1:0];
  endfunction

  function automatic sample_t sat_add(sample_t a, acc_t b);
    acc_t s;
    s = {{2{a[DATA_W-1]}}, a} + b;
    if (s > S_MAX)
      return S_MAX[DATA_W-1:0];
    else if (s < S_MIN)
      return S_MIN[DATA_W-1:0];
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/pedal_if.sv
// pedal_if: audio word, config and status bundle of the delay stage.
// master drives words/config, slave is the effect itself.
interface pedal_if #(
  parameter int ADDR_W = 10
);
  import pedal_pkg::*;

  logic              lrck;
  sample_t           sample_in;
  logic [ADDR_W-1:0] delay_len;
  logic [GAIN_W-1:0] wet_gain;
  logic [FB_W-1:0]   fb_gain;
  logic              bypass;
  sample_t           sample_out;
  logic              out_valid;
  logic              out_ch;
  logic              busy;
  logic              overrun;

  modport master (
    output lrck, sample_in, delay_len, wet_gain, fb_gain, bypass,
    input  sample_out, out_valid, out_ch, busy, overrun
  );

  modport slave (
    input  lrck, sample_in, delay_len, wet_gain, fb_gain, bypass,
    output sample_out, out_valid, out_ch, busy, overrun
  );

endinterface

// File: rtl/pedal_delay_ram.sv
// pedal_delay_ram: single-port delay line, registered read data.
// Contents have no reset; the owner clears them.
module pedal_delay_ram
  import pedal_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  sample_t       wdata,
  output sample_t       rdata
);

  sample_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pedal_delay.sv
// pedal_delay: stereo echo with feedback between i2s_rx and i2s_tx.
// L/R interleaved circular buffer, cleared after every reset.
module pedal_delay
  import pedal_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic   mck,
  input  logic   reset,
  pedal_if.slave bus
);

  localparam int RAM_AW = ADDR_W + 1;

  state_t            state_q;
  state_t            state_d;
  logic              lrck_q;
  logic              evt;
  logic              ch;
  logic [ADDR_W-1:0] wr_ptr;
  logic [RAM_AW-1:0] clr_cnt;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  sample_t           ram_wdata;
  sample_t           ram_rdata;
  sample_t           in_reg;
  sample_t           wdata_q;
  sample_t           delayed;
  sample_t           mix_out;
  sample_t           mix_wr;
  logic [GAIN_W-1:0] wet_g;

  assign evt      = bus.lrck != lrck_q;
  assign bus.busy = state_q == CLEAR;

  assign wet_g   = (bus.wet_gain > 4'd8) ? 4'd8 : bus.wet_gain;
  assign delayed = (bus.delay_len == '0) ? '0 : ram_rdata;
  assign mix_out = bus.bypass ? in_reg
                 : sat_add(in_reg, scale(delayed, wet_g));
  assign mix_wr  = bus.bypass ? in_reg
                 : sat_add(in_reg, scale(delayed, {1'b0, bus.fb_gain}));

  pedal_delay_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk  (mck),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_addr  = {wr_ptr, ch};
    ram_wdata = wdata_q;
    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
        if (&clr_cnt)
          state_d = IDLE;
      end
      IDLE: begin
        if (evt) begin
          ram_addr = {wr_ptr - bus.delay_len, lrck_q};
          state_d  = MIX;
        end
      end
      MIX:
        state_d = WRITE;
      WRITE: begin
        ram_we  = 1'b1;
        state_d = IDLE;
      end
      default:
        state_d = CLEAR;
    endcase
  end

  always_ff @(posedge mck) begin
    if (reset) begin
      state_q        <= CLEAR;
      lrck_q         <= bus.lrck;
      ch             <= 1'b0;
      wr_ptr         <= '0;
      clr_cnt        <= '0;
      in_reg         <= '0;
      wdata_q        <= '0;
      bus.sample_out <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_ch     <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lrck_q        <= bus.lrck;
      bus.out_valid <= 1'b0;
      if (state_q == CLEAR)
        clr_cnt <= clr_cnt + 1'b1;
      if (evt) begin
        case (state_q)
          CLEAR: begin
            bus.sample_out <= bus.sample_in;
            bus.out_ch     <= lrck_q;
            bus.out_valid  <= 1'b1;
          end
          IDLE: begin
            in_reg <= bus.sample_in;
            ch     <= lrck_q;
          end
          default:
            bus.overrun <= 1'b1;
        endcase
      end
      // Output registers load at the end of MIX so they show during WRITE.
      if (state_q == MIX) begin
        bus.sample_out <= mix_out;
        bus.out_ch     <= ch;
        bus.out_valid  <= 1'b1;
        wdata_q        <= mix_wr;
      end
      if (state_q == WRITE && ch)
        wr_ptr <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_pedal_delay.sv
// tb_pedal_delay: directed scenarios for the delay stage, ADDR_W=4,
// lrck half-period of 64 mck.
module tb_pedal_delay;
  import pedal_pkg::*;

  localparam int AW   = 4;
  localparam int HALF = 64;

  logic mck   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 mck = ~mck;

  pedal_if #(.ADDR_W(AW)) bus ();

  pedal_delay #(
    .ADDR_W(AW)
  ) dut (
    .mck  (mck),
    .reset(reset),
    .bus  (bus)
  );

  task automatic set_cfg(input logic [AW-1:0] d, input logic [3:0] w,
                         input logic [2:0] fb, input logic b);
    bus.delay_len = d;
    bus.wet_gain  = w;
    bus.fb_gain   = fb;
    bus.bypass    = b;
  endtask

  task automatic wait_clear;
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(posedge mck); #1;
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_timeout: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    bus.lrck = 1'b0;
    repeat (3) @(posedge mck);
    #1;
    reset = 1'b0;
    wait_clear();
  endtask

  // One word: toggle lrck, expect out_valid exactly two cycles later.
  task automatic send(input logic [23:0] val, input logic [23:0] exp,
                      input string nm);
    logic chx;
    repeat (HALF - 2) @(posedge mck);
    #1;
    chx           = bus.lrck;
    bus.sample_in = val;
    bus.lrck      = ~bus.lrck;
    @(posedge mck); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early: out_valid=%b at E+1, want 0",
               nm, bus.out_valid);
    end
    @(posedge mck); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sample_out !== exp
        || bus.out_ch !== chx) begin
      errors++;
      $display("FAIL %s: valid=%b out=%h ch=%b, want valid=1 out=%h ch=%b",
               nm, bus.out_valid, bus.sample_out, bus.out_ch, exp, chx);
    end
  endtask

  task automatic test_reset;
    int  n   = 0;
    bit  bad = 0;
    reset = 1'b1;
    repeat (3) @(posedge mck);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.sample_out !== 24'h0
        || bus.out_valid !== 1'b0 || bus.out_ch !== 1'b0
        || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: busy=%b out=%h valid=%b ch=%b ovr=%b",
               bus.busy, bus.sample_out, bus.out_valid, bus.out_ch,
               bus.overrun);
    end
    reset = 1'b0;
    while (bus.busy === 1'b1 && n < 200) begin
      if (bus.sample_out !== 24'h0 || bus.overrun !== 1'b0)
        bad = 1;
      @(posedge mck); #1;
      n++;
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL busy_len: busy cycles=%0d want 32", n);
    end
    repeat (10) @(posedge mck);
    #1;
    if (bus.sample_out !== 24'h0 || bus.overrun !== 1'b0)
      bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_quiet: out=%h ovr=%b want 0 throughout",
               bus.sample_out, bus.overrun);
    end
  endtask

  task automatic test_impulse;
    do_reset();
    set_cfg(3, 8, 0, 0);
    for (int f = 0; f < 5; f++) begin
      send(f == 0 ? 24'h100000 : 24'h0,
           (f == 0 || f == 3) ? 24'h100000 : 24'h0,
           $sformatf("impulse f%0d L", f));
      send(24'h0, 24'h0, $sformatf("impulse f%0d R", f));
    end
  endtask

  task automatic test_feedback;
    logic [23:0] e;
    do_reset();
    set_cfg(2, 8, 4, 0);
    for (int f = 0; f < 7; f++) begin
      case (f)
        0, 2:    e = 24'h400000;
        4:       e = 24'h200000;
        6:       e = 24'h100000;
        default: e = 24'h0;
      endcase
      send(f == 0 ? 24'h400000 : 24'h0, e,
           $sformatf("feedback f%0d L", f));
      send(24'h0, 24'h0, $sformatf("feedback f%0d R", f));
    end
  endtask

  task automatic test_saturation;
    do_reset();
    set_cfg(1, 8, 0, 0);
    for (int f = 0; f < 4; f++) begin
      send(24'h7FFFFF, 24'h7FFFFF, $sformatf("sat_pos f%0d L", f));
      send(24'h7FFFFF, 24'h7FFFFF, $sformatf("sat_pos f%0d R", f));
    end
    do_reset();
    for (int f = 0; f < 4; f++) begin
      send(24'h800000, 24'h800000, $sformatf("sat_neg f%0d L", f));
      send(24'h800000, 24'h800000, $sformatf("sat_neg f%0d R", f));
    end
  endtask

  task automatic test_bypass;
    do_reset();
    set_cfg(2, 8, 0, 1);
    send(24'h123456, 24'h123456, "bypass f0 L");
    send(24'h0ABCDE, 24'h0ABCDE, "bypass f0 R");
    send(24'h0, 24'h0, "bypass f1 L");
    send(24'h0, 24'h0, "bypass f1 R");
    bus.bypass = 1'b0;
    send(24'h0, 24'h123456, "unbypass f2 L");
    send(24'h0, 24'h0ABCDE, "unbypass f2 R");
    send(24'h010000, 24'h010000, "unbypass f3 L");
    send(24'h0, 24'h0, "unbypass f3 R");
  endtask

  // 18 frames so the read slot wraps onto data written 16 frames earlier.
  task automatic test_delay0;
    logic [23:0] l;
    logic [23:0] r;
    do_reset();
    set_cfg(0, 8, 0, 0);
    for (int f = 0; f < 18; f++) begin
      l = 24'h010101 * (f + 1);
      r = 24'h700000 + 24'(f);
      send(l, l, $sformatf("dly0 f%0d L", f));
      send(r, r, $sformatf("dly0 f%0d R", f));
    end
  endtask

  task automatic test_overrun;
    do_reset();
    set_cfg(3, 8, 0, 0);
    repeat (HALF - 2) @(posedge mck);
    #1;
    bus.sample_in = 24'h0F0F0F;
    bus.lrck      = ~bus.lrck;
    @(posedge mck); #1;
    @(posedge mck); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sample_out !== 24'h0F0F0F
        || bus.out_ch !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: valid=%b out=%h ch=%b want 1 0f0f0f 0",
               bus.out_valid, bus.sample_out, bus.out_ch);
    end
    bus.sample_in = 24'h777777;
    bus.lrck      = ~bus.lrck;
    @(posedge mck); #1;
    checks++;
    if (bus.overrun !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_set: overrun=%b valid=%b want 1 0",
               bus.overrun, bus.out_valid);
    end
    @(posedge mck); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drop: out_valid=%b want 0", bus.out_valid);
    end
    send(24'h050505, 24'h050505, "ovr_next L");
    send(24'h060606, 24'h060606, "ovr_next R");
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: overrun=%b want 1", bus.overrun);
    end
    repeat (HALF - 2) @(posedge mck);
    #1;
    bus.sample_in = 24'h654321;
    bus.lrck      = ~bus.lrck;
    @(posedge mck); #1;
    reset    = 1'b1;
    bus.lrck = 1'b0;
    @(posedge mck); #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.overrun !== 1'b0
        || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mix: busy=%b ovr=%b valid=%b want 1 0 0",
               bus.busy, bus.overrun, bus.out_valid);
    end
    reset = 1'b0;
    wait_clear();
    for (int f = 0; f < 4; f++) begin
      send(24'h0, 24'h0, $sformatf("stale f%0d L", f));
      send(24'h0, 24'h0, $sformatf("stale f%0d R", f));
    end
  endtask

  initial begin
    bus.lrck      = 1'b0;
    bus.sample_in = '0;
    set_cfg(0, 0, 0, 0);
    test_reset();
    test_impulse();
    test_feedback();
    test_saturation();
    test_bypass();
    test_delay0();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
